// File: rtl/spi_master_ctrl_pkg.sv
// Shared types for the SPI master: FSM state encoding, command opcodes and a small
// helper used to size the shared wait/gap counter.
package SPI_master_shared_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEL,
    SHIFT,
    WAIT,
    RECV,
    GAP
  } SPI_master_state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_rx_shreg.sv
// 8-bit MSB-first MISO deserialiser with a separate output register that captures
// the completed byte, including the bit arriving on the same edge as the load.
module spi_master_rx_shreg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       miso,
  input  logic       shift_en,
  input  logic       load,
  output logic [7:0] data_out
);

  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    sh_d   = shift_en ? {sh_q[6:0], miso} : sh_q;
    // Loading from sh_d lets the final RECV edge publish all 8 bits at once.
    data_d = load ? sh_d : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= 8'h00;
      data_q <= 8'h00;
    end else begin
      sh_q   <= sh_d;
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises 10-bit commands as SS_n frames on MOSI and, for read-data
// commands, collects the slave's 8-bit reply on MISO after a fixed turnaround.
module spi_master_ctrl
  import SPI_master_shared_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);

  localparam int CNT_MAX = max2(RD_LATENCY, IDLE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(IDLE_GAP - 1);

  SPI_master_state_e state_q, state_d;
  logic [9:0]        cmd_q, cmd_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rx_shift_en;
  logic              rx_load;

  // Outputs are computed for the state being entered, so they register in step with it.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    ss_n_d      = 1'b0;
    mosi_d      = 1'b0;
    cmd_ready_d = 1'b0;
    busy_d      = 1'b1;
    rd_valid_d  = 1'b0;
    rx_shift_en = 1'b0;
    rx_load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ss_n_d      = 1'b1;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_d       = cmd_data;
          state_d     = START;
          ss_n_d      = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      START: begin
        state_d = SEL;
        mosi_d  = cmd_q[9];
      end
      SEL: begin
        state_d   = SHIFT;
        bit_cnt_d = 4'd9;
        mosi_d    = cmd_q[9];
      end
      SHIFT: begin
        if (bit_cnt_q != 4'd0) begin
          bit_cnt_d = bit_cnt_q - 4'd1;
          mosi_d    = cmd_q[bit_cnt_d];
        end else if (cmd_q[9:8] == OP_RD_DATA) begin
          if (RD_LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d   = RECV;
            bit_cnt_d = 4'd7;
          end
        end else begin
          state_d = GAP;
          ss_n_d  = 1'b1;
          cnt_d   = GAP_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = RECV;
          bit_cnt_d = 4'd7;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECV: begin
        rx_shift_en = 1'b1;
        if (bit_cnt_q == 4'd0) begin
          rx_load    = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = GAP;
          ss_n_d     = 1'b1;
          cnt_d      = GAP_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      GAP: begin
        ss_n_d = 1'b1;
        if (cnt_q == '0) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        ss_n_d      = 1'b1;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= 10'h000;
      bit_cnt_q   <= 4'd0;
      cnt_q       <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  spi_master_rx_shreg u_rx_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .miso     (MISO),
    .shift_en (rx_shift_en),
    .load     (rx_load),
    .data_out (rd_data)
  );

  assign cmd_ready = cmd_ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default timing and RD_LATENCY=3/IDLE_GAP=4)
// driven by directed and random frames, checked against a frame-level slave/host model.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd_valid;
  logic [1:0] cmd_ready_w;
  logic [9:0] cmd_data [2];
  logic [1:0] ss_n_w;
  logic [1:0] mosi_w;
  logic [1:0] miso;
  logic [7:0] rd_data_w [2];
  logic [1:0] rd_valid_w;
  logic [1:0] busy_w;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_LATENCY(2), .IDLE_GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd_data(cmd_data[0]), .SS_n(ss_n_w[0]), .MOSI(mosi_w[0]), .MISO(miso[0]),
    .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .busy(busy_w[0])
  );

  spi_master_ctrl #(.RD_LATENCY(3), .IDLE_GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd_data(cmd_data[1]), .SS_n(ss_n_w[1]), .MOSI(mosi_w[1]), .MISO(miso[1]),
    .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .busy(busy_w[1])
  );

  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : 2;
  endfunction

  function automatic int gap_of(input int s);
    return (s == 1) ? 4 : 1;
  endfunction

  // Expected frame: one START zero, the selector bit, then the 10 command bits MSB first.
  function automatic logic [63:0] exp_mosi(input logic [9:0] cmd);
    logic [63:0] v;
    v = 64'd0;
    v[1] = cmd[9];
    for (int i = 0; i < 10; i++) v[2 + i] = cmd[9 - i];
    return v;
  endfunction

  function automatic int exp_len(input int s, input logic [9:0] cmd);
    return (cmd[9:8] == 2'b11) ? 12 + lat_of(s) + 8 : 12;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with instance s idle; returns at the negedge of its next IDLE cycle.
  task automatic run_frame(input int s, input logic [9:0] cmd, input logic [7:0] byte_v,
                           input bit hold, input logic [9:0] next_cmd, input string tag);
    int idx, n, bad, pulses, win;
    bit rd;
    logic [63:0] mosi_obs;
    rd  = (cmd[9:8] == 2'b11);
    win = 12 + lat_of(s);
    check({tag, ".ready_idle"}, 64'(cmd_ready_w[s]), 64'd1);
    cmd_valid[s] = 1'b1;
    cmd_data[s]  = cmd;
    @(negedge clk);
    if (!hold) cmd_valid[s] = 1'b0;
    idx = 0; bad = 0; pulses = 0; mosi_obs = 64'd0;
    while (ss_n_w[s] === 1'b0 && idx < 64) begin
      mosi_obs[idx] = mosi_w[s];
      if (cmd_ready_w[s] !== 1'b0 || busy_w[s] !== 1'b1) bad++;
      if (rd_valid_w[s] !== 1'b0) pulses++;
      cmd_data[s] = 10'($urandom);
      if (rd && idx >= win && idx < win + 8) miso[s] = byte_v[7 - (idx - win)];
      else if (rd && idx < win) miso[s] = ~byte_v[7];
      else if (rd) miso[s] = ~byte_v[0];
      else miso[s] = 1'($urandom);
      idx++;
      @(negedge clk);
    end
    miso[s] = 1'($urandom);
    check({tag, ".ss_low_len"}, 64'(idx), 64'(exp_len(s, cmd)));
    check({tag, ".mosi"}, mosi_obs, exp_mosi(cmd));
    check({tag, ".frame_ctl"}, 64'(bad), 64'd0);
    check({tag, ".rdv_in_frame"}, 64'(pulses), 64'd0);
    if (rd) last_rd[s] = byte_v;
    check({tag, ".rd_valid"}, 64'(rd_valid_w[s]), 64'(rd));
    check({tag, ".rd_data"}, 64'(rd_data_w[s]), 64'(last_rd[s]));
    n = 0; bad = 0; pulses = 0;
    while (cmd_ready_w[s] !== 1'b1 && n < 32) begin
      if (ss_n_w[s] !== 1'b1 || busy_w[s] !== 1'b1 || mosi_w[s] !== 1'b0) bad++;
      if (n > 0 && rd_valid_w[s] !== 1'b0) pulses++;
      cmd_data[s] = 10'($urandom);
      n++;
      @(negedge clk);
    end
    check({tag, ".gap_len"}, 64'(n), 64'(gap_of(s)));
    check({tag, ".gap_ctl"}, 64'(bad), 64'd0);
    check({tag, ".rdv_after"}, 64'(pulses) + 64'(rd_valid_w[s]), 64'd0);
    check({tag, ".idle"}, {62'd0, ss_n_w[s], busy_w[s]}, 64'd2);
    check({tag, ".rd_hold"}, 64'(rd_data_w[s]), 64'(last_rd[s]));
    cmd_data[s] = hold ? next_cmd : 10'($urandom);
  endtask

  task automatic random_frames(input int s, input int count);
    logic [9:0] c, nc;
    bit h;
    c = 10'($urandom);
    for (int i = 0; i < count; i++) begin
      nc = 10'($urandom);
      h  = (i == count - 1) ? 1'b0 : 1'($urandom);
      run_frame(s, c, 8'($urandom), h, nc, "rnd");
      c = nc;
      if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rst_n       = 1'b0;
    cmd_valid   = 2'b00;
    miso        = 2'b00;
    cmd_data[0] = 10'h000;
    cmd_data[1] = 10'h000;
    last_rd[0]  = 8'h00;
    last_rd[1]  = 8'h00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset.ss_n", 64'(ss_n_w[s]), 64'd1);
      check("reset.mosi", 64'(mosi_w[s]), 64'd0);
      check("reset.ready", 64'(cmd_ready_w[s]), 64'd1);
      check("reset.rd_data", 64'(rd_data_w[s]), 64'd0);
      check("reset.rd_valid", 64'(rd_valid_w[s]), 64'd0);
      check("reset.busy", 64'(busy_w[s]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 10'h0AA, 8'h00, 1'b0, 10'h000, "t1_wr_addr");
    run_frame(0, 10'h155, 8'h00, 1'b1, 10'h2AA, "t2_wr_data");
    run_frame(0, 10'h2AA, 8'h00, 1'b0, 10'h000, "t2_rd_addr");
    run_frame(0, 10'h300, 8'hA5, 1'b0, 10'h000, "t3_rd_data");
    run_frame(0, 10'h1C3, 8'h00, 1'b1, 10'h3EE, "t4_hold_a");
    run_frame(0, 10'h3EE, 8'h5A, 1'b0, 10'h000, "t4_hold_b");
    random_frames(0, 24);

    // Reset while bit 5 of the command is on MOSI.
    cmd_valid[0] = 1'b1;
    cmd_data[0]  = 10'h3E5;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("t5.pre_mosi_b5", {62'd0, ss_n_w[0], mosi_w[0]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5.ss_n", 64'(ss_n_w[0]), 64'd1);
    check("t5.mosi", 64'(mosi_w[0]), 64'd0);
    check("t5.busy_ready", {62'd0, busy_w[0], cmd_ready_w[0]}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_valid_w !== 2'b00) pulses++;
    end
    check("t5.no_rd_valid", 64'(pulses), 64'd0);
    check("t5.rd_data_clear", 64'(rd_data_w[0]), 64'd0);
    run_frame(0, 10'h35C, 8'h3C, 1'b0, 10'h000, "t5_after_reset");

    run_frame(1, 10'h300, 8'hF0, 1'b1, 10'h3FF, "t6_rd_f0");
    run_frame(1, 10'h3FF, 8'h96, 1'b1, 10'h0C3, "t6_rd_96");
    run_frame(1, 10'h0C3, 8'h00, 1'b0, 10'h000, "t6_wr");
    random_frames(1, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
